// File: rtl/mem_ctrl_64.sv
// mem_ctrl_64: single-outstanding request controller for a 64-word memory chip.
// ROM at 0x00-0x0F, RAM0 at 0x10-0x17, RAM1 at 0x28-0x2F; everything else errors.
module mem_ctrl_64 #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_addr,
    input  logic        req_we,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_rdata,
    output logic        resp_err,
    output logic [5:0]  mem_addr,
    output logic        mem_rw,
    output logic [15:0] mem_din,
    input  logic [15:0] mem_dout
);

    localparam logic [3:0] LP_LOAD = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic        r_err;
    logic [15:0] r_rdata;
    logic [5:0]  r_mem_addr;
    logic [15:0] r_mem_din;
    logic        w_hs;
    logic        w_legal;
    logic        w_last;

    always_comb begin
        w_legal = 1'b0;
        unique case (1'b1)
            (req_addr[5:4] == 2'b00):  w_legal = !req_we;
            (req_addr[5:3] == 3'b010): w_legal = 1'b1;
            (req_addr[5:3] == 3'b101): w_legal = 1'b1;
            default:                   w_legal = 1'b0;
        endcase
    end

    assign req_ready  = (r_state == S_IDLE) && rst_n;
    assign w_hs       = req_valid && req_ready;
    assign w_last     = (r_state == S_ACCESS) && (r_cnt == 4'd0);
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign mem_addr   = r_mem_addr;
    assign mem_din    = r_mem_din;
    // Strobe decoded from registered state so an async reset drops it at once.
    assign mem_rw     = (r_state == S_ACCESS) && r_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_hs) begin
                    w_next = w_legal ? S_SETUP : S_RESP;
                end
            end
            S_SETUP: begin
                w_next = S_ACCESS;
            end
            S_ACCESS: begin
                if (r_cnt == 4'd0) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= 4'd0;
            r_we       <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= 16'd0;
            r_mem_addr <= 6'd0;
            r_mem_din  <= 16'd0;
        end else begin
            if (w_hs) begin
                r_we    <= req_we;
                r_err   <= !w_legal;
                r_rdata <= 16'd0;
                // Rejected requests leave the chip bus exactly as it was.
                if (w_legal) begin
                    r_mem_addr <= req_addr;
                    r_mem_din  <= req_wdata;
                end
            end
            if (r_state == S_SETUP) begin
                r_cnt <= LP_LOAD;
            end else if ((r_state == S_ACCESS) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_last && !r_we) begin
                r_rdata <= mem_dout;
            end
        end
    end

endmodule
